// File: rtl/gf180mcu_ocd_io__supply_seq_pkg.sv
// Shared types and constants for the IO-ring supply sequencer.
//   seq_state_t    : sequencer FSM state encoding
//   *_DEF          : default parameter values for the sequencer top
//   FAULT_IDX_W    : width of the domain index / FAULT_IDX port (3 -> up to 8 domains)
//   timer_width()  : state-timer width able to hold max(TMO_CYC, SETTLE_CYC)
//   dom_mask_le/lt : enable masks with bits [idx:0] or [idx-1:0] set
package gf180mcu_ocd_io__supply_seq_pkg;

  localparam int N_DOM_DEF      = 3;
  localparam int DEB_CYC_DEF    = 4;
  localparam int SETTLE_CYC_DEF = 8;
  localparam int TMO_CYC_DEF    = 64;
  localparam int MAX_RETRY_DEF  = 2;

  localparam int FAULT_IDX_W = 3;
  localparam int MAX_DOM     = 1 << FAULT_IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP,
    ST_SETTLE,
    ST_UP,
    ST_DOWN,
    ST_FAULT
  } seq_state_t;

  function automatic int timer_width(input int tmo, input int settle);
    int m;
    m = (tmo > settle) ? tmo : settle;
    return $clog2(m + 1);
  endfunction

  // Bits [idx:0] set; idx = 7 wraps the shift to zero and yields all ones.
  function automatic logic [MAX_DOM-1:0] dom_mask_le(input logic [FAULT_IDX_W-1:0] idx);
    return (MAX_DOM'(2) << idx) - MAX_DOM'(1);
  endfunction

  // Bits [idx-1:0] set (empty for idx = 0).
  function automatic logic [MAX_DOM-1:0] dom_mask_lt(input logic [FAULT_IDX_W-1:0] idx);
    return (MAX_DOM'(1) << idx) - MAX_DOM'(1);
  endfunction

endpackage

// File: rtl/gf180mcu_ocd_io__pg_debounce.sv
// One power-good channel: 2-FF synchroniser followed by a debouncer.
//   clk, rst : clock and asynchronous active-high reset
//   pg_raw   : asynchronous power-good from the pad ring
//   pg_db    : debounced power-good; follows the synchronised value only after
//              it has differed from pg_db for DEB_CYC consecutive cycles
module gf180mcu_ocd_io__pg_debounce
  import gf180mcu_ocd_io__supply_seq_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pg_raw,
  output logic pg_db
);

  localparam int CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);

  logic          sync_reg;
  logic          pg_s_reg;
  logic          pg_db_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg  <= 1'b0;
      pg_s_reg  <= 1'b0;
      pg_db_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync_reg <= pg_raw;
      pg_s_reg <= sync_reg;
      // Any agreement restarts the run of differing cycles.
      if (pg_s_reg == pg_db_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEB_CYC - 1)) begin
        pg_db_reg <= pg_s_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign pg_db = pg_db_reg;

endmodule

// File: rtl/gf180mcu_ocd_io__supply_seq.sv
// Power sequencer for the pad-ring supply domains.
// Enables N_DOM domains in ascending order, each gated on its debounced
// power-good, and powers down in reverse order. Timeouts and power-good loss
// while up latch FAULT with the offending domain index.
// Optional macro SUPPLY_SEQ_RETRY_EN: automatic retry (up to MAX_RETRY) of a
// power-up that faulted while PWR_REQ is still high.
// Ports:
//   CLK, RST   : clock, asynchronous active-high reset
//   PWR_REQ    : level request, 1 = power up, 0 = power down
//   PG_RAW     : asynchronous per-domain power-good
//   EN         : per-domain supply enable
//   ALL_GOOD   : all domains up and good
//   FAULT      : latched sequencing fault, FAULT_IDX = domain responsible
//   DVDD/DVSS/VDD : pad-ring supply nets, passed through with no logic
module gf180mcu_ocd_io__supply_seq
  import gf180mcu_ocd_io__supply_seq_pkg::*;
#(
  parameter int N_DOM      = N_DOM_DEF,
  parameter int DEB_CYC    = DEB_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int TMO_CYC    = TMO_CYC_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   PWR_REQ,
  input  logic [N_DOM-1:0]       PG_RAW,
  output logic [N_DOM-1:0]       EN,
  output logic                   ALL_GOOD,
  output logic                   FAULT,
  output logic [FAULT_IDX_W-1:0] FAULT_IDX,
  inout  wire                    DVDD,
  inout  supply0                 DVSS,
  inout  wire                    VDD
);

  localparam int TW = timer_width(TMO_CYC, SETTLE_CYC);

  seq_state_t             state_reg, state_next;
  logic [FAULT_IDX_W-1:0] idx_reg, idx_next;
  logic [FAULT_IDX_W-1:0] fault_idx_reg, fault_idx_next;
  logic [TW-1:0]          timer_reg, timer_next;
  logic [N_DOM-1:0]       en_reg, en_next;
  logic                   all_good_reg, all_good_next;
  logic                   fault_reg, fault_next;
  logic [N_DOM-1:0]       pg_db;
  logic [MAX_DOM-1:0]     pg_ext;
  logic [FAULT_IDX_W-1:0] first_bad;
  logic                   any_bad, settle_done, ramp_timeout;

  for (genvar gi = 0; gi < N_DOM; gi++) begin : g_pg
    gf180mcu_ocd_io__pg_debounce #(
      .DEB_CYC (DEB_CYC)
    ) u_pg (
      .clk    (CLK),
      .rst    (RST),
      .pg_raw (PG_RAW[gi]),
      .pg_db  (pg_db[gi])
    );
  end

  // Widened so a 3-bit index never selects outside the vector.
  assign pg_ext       = MAX_DOM'(pg_db);
  assign settle_done  = (timer_reg == TW'(SETTLE_CYC - 1));
  assign ramp_timeout = (timer_reg == TW'(TMO_CYC - 1));

`ifdef SUPPLY_SEQ_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] retry_cnt_reg;
  logic          retry_armed_reg;

  // Retry budget is spent on each FAULT entry made with the request still high.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      retry_cnt_reg   <= '0;
      retry_armed_reg <= 1'b0;
    end else if (state_next == ST_IDLE || state_next == ST_UP) begin
      retry_cnt_reg   <= '0;
      retry_armed_reg <= 1'b0;
    end else if (state_next == ST_FAULT && state_reg != ST_FAULT) begin
      if (PWR_REQ && retry_cnt_reg < RW'(MAX_RETRY)) begin
        retry_cnt_reg   <= retry_cnt_reg + RW'(1);
        retry_armed_reg <= 1'b1;
      end else begin
        retry_armed_reg <= 1'b0;
      end
    end
  end
`endif

  // State register plus registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      timer_reg     <= '0;
      en_reg        <= '0;
      all_good_reg  <= 1'b0;
      fault_reg     <= 1'b0;
      fault_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      timer_reg     <= timer_next;
      en_reg        <= en_next;
      all_good_reg  <= all_good_next;
      fault_reg     <= fault_next;
      fault_idx_reg <= fault_idx_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    fault_idx_next = fault_idx_reg;
    any_bad        = 1'b0;
    first_bad      = '0;
    // Scan downward so the lowest failing domain is the one kept.
    for (int j = N_DOM - 1; j >= 0; j--) begin
      if (!pg_db[j]) begin
        any_bad   = 1'b1;
        first_bad = FAULT_IDX_W'(j);
      end
    end

    case (state_reg)
      ST_IDLE: begin
        if (PWR_REQ) begin
          state_next = ST_RAMP;
          idx_next   = '0;
        end
      end
      ST_RAMP: begin
        // Power-good is checked before the timeout so a same-cycle rise wins.
        if (!PWR_REQ) begin
          state_next = ST_DOWN;
        end else if (pg_ext[idx_reg]) begin
          state_next = (idx_reg == FAULT_IDX_W'(N_DOM - 1)) ? ST_UP : ST_SETTLE;
        end else if (ramp_timeout) begin
          state_next     = ST_FAULT;
          fault_idx_next = idx_reg;
        end
      end
      ST_SETTLE: begin
        if (!PWR_REQ) begin
          state_next = ST_DOWN;
        end else if (settle_done) begin
          state_next = ST_RAMP;
          idx_next   = idx_reg + FAULT_IDX_W'(1);
        end
      end
      ST_UP: begin
        if (any_bad) begin
          state_next     = ST_FAULT;
          fault_idx_next = first_bad;
        end else if (!PWR_REQ) begin
          state_next = ST_DOWN;
        end
      end
      ST_DOWN: begin
        // Each index step restarts the timer, giving one settle per domain.
        if (settle_done) begin
          if (idx_reg == '0) begin
            state_next = ST_IDLE;
          end else begin
            idx_next = idx_reg - FAULT_IDX_W'(1);
          end
        end
      end
      ST_FAULT: begin
        if (!PWR_REQ) begin
          state_next = ST_IDLE;
        end
`ifdef SUPPLY_SEQ_RETRY_EN
        else if (retry_armed_reg && settle_done) begin
          state_next = ST_RAMP;
          idx_next   = '0;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase

    if (state_next != state_reg || idx_next != idx_reg) begin
      timer_next = '0;
    end else if (!(&timer_reg)) begin
      timer_next = timer_reg + TW'(1);
    end else begin
      timer_next = timer_reg;
    end
  end

  // Output logic, evaluated on the next state so outputs register with it.
  always_comb begin
    en_next = '0;
    case (state_next)
      ST_RAMP, ST_SETTLE, ST_UP: en_next = N_DOM'(dom_mask_le(idx_next));
      // The current domain stays on for the first DOWN cycle so ALL_GOOD
      // has already dropped when its enable is removed.
      ST_DOWN: en_next = (timer_next == '0) ? N_DOM'(dom_mask_le(idx_next))
                                            : N_DOM'(dom_mask_lt(idx_next));
      default: en_next = '0;
    endcase
    all_good_next = (state_reg == ST_UP) && (state_next == ST_UP);
    fault_next    = (state_next == ST_FAULT);
  end

  assign EN        = en_reg;
  assign ALL_GOOD  = all_good_reg;
  assign FAULT     = fault_reg;
  assign FAULT_IDX = fault_idx_reg;

endmodule

// File: tb/tb_gf180mcu_ocd_io__supply_seq.sv
// Directed bench for gf180mcu_ocd_io__supply_seq (N_DOM=3, DEB_CYC=4,
// SETTLE_CYC=8, TMO_CYC=64). A pad model raises PG_RAW[j] 10 cycles after
// EN[j] rises (when pg_auto[j] is set), drops it with EN[j], and pg_low[j]
// forces it low for glitch injection. Build with SUPPLY_SEQ_RETRY_EN to add
// the retry scenario.
module tb_gf180mcu_ocd_io__supply_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwr_req;
  logic [2:0] pg_raw = 3'b000;
  logic [2:0] en;
  logic       all_good;
  logic       fault;
  logic [2:0] fault_idx;
  wire        dvdd;
  wire        dvss;
  wire        vdd;

  int checks = 0;
  int errors = 0;

  logic [2:0] pg_auto = 3'b000;
  logic [2:0] pg_low  = 3'b000;
  int         age [3] = '{0, 0, 0};
  logic       ag_seen;
  logic       full_seen;

  always #5 clk = ~clk;

  gf180mcu_ocd_io__supply_seq #(
    .N_DOM(3), .DEB_CYC(4), .SETTLE_CYC(8), .TMO_CYC(64), .MAX_RETRY(2)
  ) dut (
    .CLK(clk), .RST(rst), .PWR_REQ(pwr_req), .PG_RAW(pg_raw),
    .EN(en), .ALL_GOOD(all_good), .FAULT(fault), .FAULT_IDX(fault_idx),
    .DVDD(dvdd), .DVSS(dvss), .VDD(vdd)
  );

  // Pad model, updated on the falling edge away from DUT sampling.
  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) begin
      pg_raw[j] <= pg_auto[j] && !pg_low[j] && en[j] && (age[j] >= 9);
      age[j]    <= en[j] ? ((age[j] < 1000) ? age[j] + 1 : age[j]) : 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (all_good === 1'b1) ag_seen = 1'b1;
    if (en === 3'b111) full_seen = 1'b1;
  endtask

  task automatic wait_en(input logic [2:0] want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (en === want) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ag(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (all_good === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fault(input logic want, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (fault === want) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pwr_req = 1'b0;
    repeat (3) tick();
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL reset_en: got %b expected 000", en); end
    checks++; if (all_good !== 1'b0) begin errors++; $display("FAIL reset_all_good: got %b expected 0", all_good); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
    checks++; if (fault_idx !== 3'd0) begin errors++; $display("FAIL reset_fault_idx: got %0d expected 0", fault_idx); end
    rst = 1'b0;
    repeat (5) tick();
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL idle_en: got %b expected 000", en); end
    $display("test_reset done: en=%b fault=%b", en, fault);
  endtask

  task automatic test_normal_updown();
    bit ok;
    pg_auto = 3'b111; pwr_req = 1'b1;
    tick();
    checks++; if (en !== 3'b001) begin errors++; $display("FAIL up_first_en: got %b expected 001", en); end
    wait_en(3'b011, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL up_en011: got %b expected 011", en); end
    wait_en(3'b111, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL up_en111: got %b expected 111", en); end
    wait_ag(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL up_all_good: got %b expected 1", all_good); end
    pwr_req = 1'b0;
    tick();
    checks++; if (all_good !== 1'b0) begin errors++; $display("FAIL down_ag_first: got %b expected 0", all_good); end
    checks++; if (en !== 3'b111) begin errors++; $display("FAIL down_en_hold: got %b expected 111", en); end
    tick();
    checks++; if (en !== 3'b011) begin errors++; $display("FAIL down_en011: got %b expected 011", en); end
    repeat (7) tick();
    checks++; if (en !== 3'b011) begin errors++; $display("FAIL down_settle2: got %b expected 011", en); end
    tick();
    checks++; if (en !== 3'b001) begin errors++; $display("FAIL down_en001: got %b expected 001", en); end
    repeat (7) tick();
    checks++; if (en !== 3'b001) begin errors++; $display("FAIL down_settle1: got %b expected 001", en); end
    tick();
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL down_en000: got %b expected 000", en); end
    repeat (30) tick();
    checks++; if (en !== 3'b000 || all_good !== 1'b0) begin errors++; $display("FAIL down_idle: got en=%b ag=%b expected en=000 ag=0", en, all_good); end
    $display("test_normal_updown done: en=%b all_good=%b", en, all_good);
  endtask

  task automatic test_timeout();
    bit ok;
    pg_auto = 3'b101; pwr_req = 1'b1;
    wait_en(3'b011, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_reach_idx1: got %b expected 011", en); end
    repeat (63) tick();
    checks++; if (fault !== 1'b0 || en !== 3'b011) begin errors++; $display("FAIL tmo_early: got fault=%b en=%b expected fault=0 en=011", fault, en); end
    tick();
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL tmo_fault: got %b expected 1", fault); end
    checks++; if (fault_idx !== 3'd1) begin errors++; $display("FAIL tmo_fault_idx: got %0d expected 1", fault_idx); end
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL tmo_en_off: got %b expected 000", en); end
`ifndef SUPPLY_SEQ_RETRY_EN
    repeat (20) tick();
    checks++; if (fault !== 1'b1 || fault_idx !== 3'd1) begin errors++; $display("FAIL tmo_held: got fault=%b idx=%0d expected fault=1 idx=1", fault, fault_idx); end
`endif
    pwr_req = 1'b0;
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b expected 0", fault); end
    repeat (20) tick();
    $display("test_timeout done: fault=%b fault_idx=%0d", fault, fault_idx);
  endtask

  task automatic test_glitch();
    bit ok;
    pg_auto = 3'b111; pg_low = 3'b000; pwr_req = 1'b1;
    wait_ag(150, ok);
    checks++; if (!ok) begin errors++; $display("FAIL glitch_up: got %b expected 1", all_good); end
    pg_low = 3'b100;
    repeat (3) tick();
    pg_low = 3'b000;
    repeat (20) tick();
    checks++; if (fault !== 1'b0 || all_good !== 1'b1) begin errors++; $display("FAIL glitch_short: got fault=%b ag=%b expected fault=0 ag=1", fault, all_good); end
    pg_low = 3'b100;
    repeat (6) tick();
    pg_low = 3'b000;
    wait_fault(1'b1, 30, ok);
    pwr_req = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL glitch_long: got %b expected 1", fault); end
    checks++; if (fault_idx !== 3'd2) begin errors++; $display("FAIL glitch_idx: got %0d expected 2", fault_idx); end
    checks++; if (en !== 3'b000 || all_good !== 1'b0) begin errors++; $display("FAIL glitch_off: got en=%b ag=%b expected en=000 ag=0", en, all_good); end
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL glitch_clear: got %b expected 0", fault); end
    repeat (30) tick();
    $display("test_glitch done: fault=%b fault_idx=%0d", fault, fault_idx);
  endtask

  task automatic test_abort();
    bit ok;
    ag_seen = 1'b0; full_seen = 1'b0;
    pg_auto = 3'b111; pwr_req = 1'b1;
    wait_en(3'b011, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_reach: got %b expected 011", en); end
    // Domain 1 goes good about 16 cycles after its enable; settle runs to 24.
    repeat (20) tick();
    checks++; if (en !== 3'b011) begin errors++; $display("FAIL abort_settle: got %b expected 011", en); end
    pwr_req = 1'b0;
    tick();
    checks++; if (en !== 3'b011) begin errors++; $display("FAIL abort_entry: got %b expected 011", en); end
    tick();
    checks++; if (en !== 3'b001) begin errors++; $display("FAIL abort_en001: got %b expected 001", en); end
    repeat (7) tick();
    checks++; if (en !== 3'b001) begin errors++; $display("FAIL abort_hold001: got %b expected 001", en); end
    tick();
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL abort_en000: got %b expected 000", en); end
    repeat (20) tick();
    checks++; if (ag_seen !== 1'b0 || full_seen !== 1'b0) begin errors++; $display("FAIL abort_never_up: got ag_seen=%b en111_seen=%b expected 0 0", ag_seen, full_seen); end
    $display("test_abort done: en=%b", en);
  endtask

  task automatic test_async_reset();
    bit ok;
    pg_auto = 3'b111; pwr_req = 1'b1;
    wait_en(3'b011, 60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL arst_reach: got %b expected 011", en); end
    #2 rst = 1'b1;
    #1;
    checks++; if (en !== 3'b000) begin errors++; $display("FAIL arst_en: got %b expected 000", en); end
    checks++; if (fault !== 1'b0 || all_good !== 1'b0) begin errors++; $display("FAIL arst_flags: got fault=%b ag=%b expected 0 0", fault, all_good); end
    #2 rst = 1'b0;
    tick();
    checks++; if (en !== 3'b001) begin errors++; $display("FAIL arst_restart: got %b expected 001", en); end
    pwr_req = 1'b0;
    wait_en(3'b000, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL arst_down: got %b expected 000", en); end
    repeat (30) tick();
    $display("test_async_reset done: en=%b", en);
  endtask

`ifdef SUPPLY_SEQ_RETRY_EN
  task automatic test_retry();
    bit   ok;
    int   n_rise;
    int   t_first;
    int   t_second;
    logic prev;
    n_rise = 0; t_first = 0; t_second = 0; prev = 1'b0;
    pg_auto = 3'b110; pwr_req = 1'b1;
    for (int i = 0; i < 320; i++) begin
      tick();
      if (fault === 1'b1 && prev !== 1'b1) begin
        n_rise++;
        if (n_rise == 1) t_first = i;
        if (n_rise == 2) t_second = i;
      end
      prev = fault;
    end
    checks++; if (n_rise != 3) begin errors++; $display("FAIL retry_count: got %0d faults expected 3", n_rise); end
    checks++; if (t_second - t_first != 72) begin errors++; $display("FAIL retry_spacing: got %0d expected 72", t_second - t_first); end
    checks++; if (fault !== 1'b1 || fault_idx !== 3'd0 || en !== 3'b000) begin errors++; $display("FAIL retry_latched: got fault=%b idx=%0d en=%b expected 1 0 000", fault, fault_idx, en); end
    pwr_req = 1'b0;
    tick();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL retry_clear: got %b expected 0", fault); end
    repeat (30) tick();
    pwr_req = 1'b1;
    wait_fault(1'b1, 80, ok);
    checks++; if (!ok) begin errors++; $display("FAIL retry_first_fault: got %b expected 1", fault); end
    wait_fault(1'b0, 20, ok);
    checks++; if (!ok || en !== 3'b001) begin errors++; $display("FAIL retry_reramp: got fault=%b en=%b expected 0 001", fault, en); end
    pg_auto = 3'b111;
    wait_ag(120, ok);
    checks++; if (!ok || fault !== 1'b0) begin errors++; $display("FAIL retry_recover: got ag=%b fault=%b expected 1 0", all_good, fault); end
    pwr_req = 1'b0;
    repeat (60) tick();
    $display("test_retry done: faults=%0d spacing=%0d", n_rise, t_second - t_first);
  endtask
`endif

  initial begin
    test_reset();
    test_normal_updown();
    test_timeout();
    test_glitch();
    test_abort();
    test_async_reset();
`ifdef SUPPLY_SEQ_RETRY_EN
    test_retry();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
